ws2812_bit_gen: RTL and testbench

Serial waveform generator for the WS2812B chain on the Basys 3 (100 MHz `clk`). It sits directly downstream of the LED control FSM: it consumes `doGen` and `genMode`, drives the single-wire `dataOut` pin with WS2812B-timed 0/1 symbols, and pulses `shift` to advance the bit shift register. It also counts symbols and returns `sendDone` to the control FSM after a full frame.

---
 rtl/ws2812_bit_gen.sv | 129 ++++++++++++
 tb/tb_ws2812_bit_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_bit_gen.sv
// WS2812B single-wire symbol generator: emits timed 0/1 symbols, pulses shift to
// fetch the next bit from the control FSM, and flags sendDone on the last symbol.
module ws2812_bit_gen #(
    parameter int T0H      = 40,
    parameter int T1H      = 80,
    parameter int TBIT     = 125,
    parameter int NUM_BITS = 96,
    parameter int CW       = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          doGen,
    input  logic [1:0]    genMode,
    output logic          dataOut,
    output logic          shift,
    output logic          sendDone,
    output logic [CW-1:0] bitIndex
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [CW-1:0] T0H_C     = CW'(T0H);
    localparam logic [CW-1:0] T1H_C     = CW'(T1H);
    localparam logic [CW-1:0] LAST_CNT  = CW'(TBIT - 1);
    localparam logic [CW-1:0] SHIFT_CNT = CW'(TBIT - 2);
    localparam logic [CW-1:0] LAST_BIT  = CW'(NUM_BITS - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] bit_idx_q, bit_idx_d;
    logic [CW-1:0] hi_time_q, hi_time_d;
    logic          data_out_q, data_out_d;
    logic          shift_q, shift_d;
    logic          send_done_q, send_done_d;
    logic          run;
    logic [CW-1:0] sel_hi;

    always_comb begin
        run         = doGen & genMode[1];
        sel_hi      = genMode[0] ? T1H_C : T0H_C;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        hi_time_d   = hi_time_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (run) begin
                    state_d   = ST_HIGH;
                    hi_time_d = sel_hi;
                end
            end
            ST_HIGH: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == hi_time_q - ONE) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d   = ST_IDLE;
                        bit_idx_d = '0;
                    end else begin
                        // Back-to-back symbols: the next bit is sampled on this edge.
                        state_d   = ST_HIGH;
                        bit_idx_d = bit_idx_q + ONE;
                        hi_time_d = sel_hi;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                bit_idx_d = '0;
            end
        endcase

        // Losing the request mid-frame drops the partial symbol with no pulses.
        if (state_q != ST_IDLE && !run) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            bit_idx_d = '0;
        end

        data_out_d  = (state_d == ST_HIGH);
        shift_d     = (state_d == ST_LOW) && (cnt_d == SHIFT_CNT);
        send_done_d = (state_d == ST_LOW) && (cnt_d == LAST_CNT) && (bit_idx_d == LAST_BIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            data_out_q  <= 1'b0;
            shift_q     <= 1'b0;
            send_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            data_out_q  <= data_out_d;
            shift_q     <= shift_d;
            send_done_q <= send_done_d;
        end
    end

    // High time is only consulted after being latched at symbol start.
    always_ff @(posedge clk) begin
        hi_time_q <= hi_time_d;
    end

    assign dataOut  = data_out_q;
    assign shift    = shift_q;
    assign sendDone = send_done_q;
    assign bitIndex = bit_idx_q;

endmodule

// File: tb/tb_ws2812_bit_gen.sv
// Bench for ws2812_bit_gen: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a frame-time model (symbol = t / TBIT, phase = t % TBIT).
module tb_ws2812_bit_gen;

    localparam int T0H      = 40;
    localparam int T1H      = 80;
    localparam int TBIT     = 125;
    localparam int NUM_BITS = 96;
    localparam int CW       = 7;
    localparam int FRAME    = NUM_BITS * TBIT;

    logic          clk = 1'b0;
    logic          reset;
    logic          doGen;
    logic [1:0]    genMode;
    logic          dataOut;
    logic          shift;
    logic          sendDone;
    logic [CW-1:0] bitIndex;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame active flag, cycles since frame start, current high time.
    bit m_act = 1'b0;
    int m_t   = 0;
    int m_hi  = 0;
    bit e_do, e_sh, e_sd;
    int e_bi;

    ws2812_bit_gen #(
        .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .NUM_BITS(NUM_BITS), .CW(CW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .doGen   (doGen),
        .genMode (genMode),
        .dataOut (dataOut),
        .shift   (shift),
        .sendDone(sendDone),
        .bitIndex(bitIndex)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp_v);
        end
    endtask

    // One clock: inputs captured as seen at the edge, model advanced, outputs compared.
    task automatic step();
        logic       r, dg;
        logic [1:0] gm;
        r  = reset;
        dg = doGen;
        gm = genMode;
        @(posedge clk);
        #1;
        if (r || !(dg && gm[1])) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            m_act = 1'b1;
            m_t   = 0;
            m_hi  = gm[0] ? T1H : T0H;
        end else begin
            m_t++;
            if (m_t == FRAME) m_act = 1'b0;
            else if (m_t % TBIT == 0) m_hi = gm[0] ? T1H : T0H;
        end
        e_do = m_act && ((m_t % TBIT) < m_hi);
        e_sh = m_act && ((m_t % TBIT) == TBIT - 2);
        e_sd = m_act && (m_t == FRAME - 1);
        e_bi = m_act ? (m_t / TBIT) : 0;
        chk("dataOut",  32'(dataOut),  32'(e_do));
        chk("shift",    32'(shift),    32'(e_sh));
        chk("sendDone", 32'(sendDone), 32'(e_sd));
        chk("bitIndex", 32'(bitIndex), 32'(e_bi));
    endtask

    task automatic go_idle(input int n);
        doGen = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Runs one symbol period from idle with a fixed mode and checks its shape.
    task automatic single_symbol(input logic [1:0] gm, input int hi_exp);
        int hi_cnt, lo_cnt, sh_at;
        go_idle(3);
        genMode = gm;
        doGen   = 1'b1;
        hi_cnt  = 0;
        lo_cnt  = 0;
        sh_at   = -1;
        for (int i = 0; i <= TBIT; i++) begin
            step();
            if (i < TBIT) begin
                if (dataOut) hi_cnt++;
                else lo_cnt++;
            end
            if (shift) sh_at = i;
            if (i == TBIT) begin
                chk("sym_bitidx_next", 32'(bitIndex), 32'd1);
                chk("sym_next_start", 32'(dataOut), 32'd1);
            end
        end
        chk("sym_high_len", 32'(hi_cnt), 32'(hi_exp));
        chk("sym_low_len",  32'(lo_cnt), 32'(TBIT - hi_exp));
        chk("sym_shift_at", 32'(sh_at),  32'(TBIT - 2));
        go_idle(2);
    endtask

    initial begin
        logic [95:0] pat;
        int hi_len, sym, n_shift, n_sd, sd_at, ptr;

        reset   = 1'b1;
        doGen   = 1'b1;
        genMode = 2'b11;

        // Reset held with a pending request: everything stays low.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_dataOut", 32'(dataOut), 32'd0);
            chk("rst_bitIndex", 32'(bitIndex), 32'd0);
        end
        reset = 1'b0;
        step();
        chk("post_rst_start", 32'(dataOut), 32'd1);
        go_idle(3);

        single_symbol(2'b10, T0H);
        single_symbol(2'b11, T1H);

        // Full frame, genMode[0] advanced on every shift, MSB first.
        pat     = 96'hA5F00F5AC3C33C3C96699669;
        ptr     = 0;
        genMode = {1'b1, pat[95]};
        doGen   = 1'b1;
        hi_len  = 0;
        sym     = 0;
        n_shift = 0;
        n_sd    = 0;
        sd_at   = -1;
        for (int i = 0; i <= FRAME; i++) begin
            step();
            if (dataOut) begin
                hi_len++;
            end else if (hi_len > 0) begin
                if (sym < NUM_BITS)
                    chk("frame_hi_time", 32'(hi_len), pat[95 - sym] ? 32'(T1H) : 32'(T0H));
                sym++;
                hi_len = 0;
            end
            if (shift) n_shift++;
            if (sendDone) begin
                n_sd++;
                sd_at = i;
            end
            if (e_sh) begin
                ptr++;
                if (ptr < NUM_BITS) genMode[0] = pat[95 - ptr];
            end
            if (i == FRAME) begin
                chk("idle_dataOut", 32'(dataOut), 32'd0);
                chk("idle_bitIndex", 32'(bitIndex), 32'd0);
            end
        end
        chk("frame_symbols", 32'(sym), 32'(NUM_BITS));
        chk("frame_shifts", 32'(n_shift), 32'(NUM_BITS));
        chk("frame_senddone_n", 32'(n_sd), 32'd1);
        chk("frame_senddone_at", 32'(sd_at), 32'(FRAME - 1));
        go_idle(3);

        // Abort at cycle 30 of symbol 5, then a clean restart.
        genMode = 2'b11;
        doGen   = 1'b1;
        n_shift = 0;
        for (int i = 0; i < 5 * TBIT + 30; i++) begin
            step();
            if (shift) n_shift++;
        end
        chk("abort_prior_shifts", 32'(n_shift), 32'd5);
        doGen = 1'b0;
        step();
        chk("abort_dataOut", 32'(dataOut), 32'd0);
        chk("abort_bitIndex", 32'(bitIndex), 32'd0);
        n_shift = 0;
        n_sd    = 0;
        for (int i = 0; i < 2 * TBIT; i++) begin
            step();
            if (shift) n_shift++;
            if (sendDone) n_sd++;
        end
        chk("abort_no_pulses", 32'(n_shift + n_sd), 32'd0);
        single_symbol(2'b10, T0H);

        // RET: request high but mode 00 keeps the line idle.
        genMode = 2'b00;
        doGen   = 1'b1;
        n_shift = 0;
        hi_len  = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (shift || sendDone) n_shift++;
            if (dataOut) hi_len++;
        end
        chk("ret_no_pulses", 32'(n_shift), 32'd0);
        chk("ret_line_low", 32'(hi_len), 32'd0);
        genMode = 2'b11;
        step();
        chk("ret_exit_start", 32'(dataOut), 32'd1);

        // Randomized traffic: random bit values, occasional aborts, RET and resets.
        for (int i = 0; i < 30000; i++) begin
            int r;
            r = int'($urandom_range(0, 9999));
            reset      = (r < 2);
            doGen      = !(r >= 2 && r < 6);
            genMode[1] = !(r >= 6 && r < 9);
            genMode[0] = 1'($urandom_range(0, 1));
            step();
        end
        reset = 1'b0;
        go_idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
